// File: rtl/a2d_spi_intf_if.sv
// a2d_spi_intf_if: bundles the conversion handshake with the A2D SPI pins.
//   strt_cnv, chnnl : conversion request from the motion controller
//   cnv_cmplt, res  : completion flag and 12-bit result back to the controller
//   SS_n, SCLK, MOSI: SPI outputs to the A2D; MISO: SPI data from the A2D
// Modport slave is the converter's view; master is the controller/A2D side.
interface a2d_spi_intf_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport slave (
    input  strt_cnv, chnnl, MISO,
    output cnv_cmplt, res, SS_n, SCLK, MOSI
  );

  modport master (
    output strt_cnv, chnnl, MISO,
    input  cnv_cmplt, res, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/a2d_spi_intf.sv
// a2d_spi_intf: SPI mode-3 master for an 8-channel 12-bit A2D.
// Each request runs two 16-bit frames separated by GAP_CLKS clks of SS_n
// high; frame 1 sends the channel command, frame 2 resends it and shifts
// back the result.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : a2d_spi_intf_if.slave
//                strt_cnv/chnnl in, cnv_cmplt/res out,
//                SS_n/SCLK/MOSI out (registered), MISO in
// SCLK is clk/32 taken from bit 4 of a 5-bit divider; the divider is
// preloaded with 23 so the first SCLK fall lands 9 clks after SS_n falls.
module a2d_spi_intf #(
  parameter int unsigned GAP_CLKS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  a2d_spi_intf_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FRAME1, GAP, FRAME2} state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CLKS - 1);

  state_t      state, state_nxt;
  logic [15:0] shft, shft_nxt;
  logic [15:0] shft_in;
  logic [2:0]  chnl_q, chnl_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [4:0]  rise_cnt, rise_cnt_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic        skip_fall, skip_fall_nxt;
  logic        miso_smp, miso_smp_nxt;
  logic        ss_n, ss_n_nxt;
  logic        sclk, sclk_nxt;
  logic        mosi, mosi_nxt;
  logic        cmplt, cmplt_nxt;
  logic [11:0] res_q, res_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shft      <= '0;
      chnl_q    <= '0;
      cnt       <= '0;
      rise_cnt  <= '0;
      gap_cnt   <= '0;
      skip_fall <= 1'b0;
      miso_smp  <= 1'b0;
      ss_n      <= 1'b1;
      sclk      <= 1'b1;
      mosi      <= 1'b0;
      cmplt     <= 1'b0;
      res_q     <= '0;
    end else begin
      state     <= state_nxt;
      shft      <= shft_nxt;
      chnl_q    <= chnl_nxt;
      cnt       <= cnt_nxt;
      rise_cnt  <= rise_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      skip_fall <= skip_fall_nxt;
      miso_smp  <= miso_smp_nxt;
      ss_n      <= ss_n_nxt;
      sclk      <= sclk_nxt;
      mosi      <= mosi_nxt;
      cmplt     <= cmplt_nxt;
      res_q     <= res_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shft_nxt      = shft;
    chnl_nxt      = chnl_q;
    cnt_nxt       = cnt;
    rise_cnt_nxt  = rise_cnt;
    gap_cnt_nxt   = gap_cnt;
    skip_fall_nxt = skip_fall;
    miso_smp_nxt  = miso_smp;
    ss_n_nxt      = ss_n;
    sclk_nxt      = sclk;
    cmplt_nxt     = cmplt;
    res_nxt       = res_q;
    shft_in       = {shft[14:0], miso_smp};

    case (state)
      IDLE: begin
        if (bus.strt_cnv) begin
          chnl_nxt      = bus.chnnl;
          shft_nxt      = {2'b00, bus.chnnl, 11'h000};
          cmplt_nxt     = 1'b0;
          ss_n_nxt      = 1'b0;
          cnt_nxt       = 5'd23;
          rise_cnt_nxt  = '0;
          skip_fall_nxt = 1'b1;
          sclk_nxt      = 1'b1;
          state_nxt     = FRAME1;
        end
      end

      FRAME1, FRAME2: begin
        cnt_nxt  = cnt + 5'd1;
        sclk_nxt = cnt_nxt[4];
        // Rising SCLK: capture the A2D bit.
        if (cnt == 5'd15) begin
          miso_smp_nxt = bus.MISO;
          rise_cnt_nxt = rise_cnt + 5'd1;
        end
        // Falling SCLK: advance the shifter, except on the frame's first fall.
        if (cnt == 5'd31) begin
          if (skip_fall) skip_fall_nxt = 1'b0;
          else           shft_nxt      = shft_in;
        end
        // The 16th shift is taken one clk ahead of the would-be 17th fall:
        // SCLK is already high and the last sample is in, and closing here
        // keeps SS_n low for exactly 520 clks.
        if (rise_cnt == 5'd16 && cnt == 5'd30) begin
          shft_nxt = shft_in;
          ss_n_nxt = 1'b1;
          sclk_nxt = 1'b1;
          cnt_nxt  = '0;
          if (state == FRAME1) begin
            gap_cnt_nxt = '0;
            state_nxt   = GAP;
          end else begin
            res_nxt   = shft_in[11:0];
            cmplt_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          shft_nxt      = {2'b00, chnl_q, 11'h000};
          ss_n_nxt      = 1'b0;
          cnt_nxt       = 5'd23;
          rise_cnt_nxt  = '0;
          skip_fall_nxt = 1'b1;
          state_nxt     = FRAME2;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    mosi_nxt = ss_n_nxt ? 1'b0 : shft_nxt[15];
  end

  assign bus.SS_n      = ss_n;
  assign bus.SCLK      = sclk;
  assign bus.MOSI      = mosi;
  assign bus.cnv_cmplt = cmplt;
  assign bus.res       = res_q;

endmodule

// File: tb/tb_a2d_spi_intf.sv
// tb_a2d_spi_intf: directed bench for a2d_spi_intf with a behavioural A2D.
// Two instances: default GAP_CLKS and GAP_CLKS=2; sel picks which one the
// A2D model and frame monitor follow.
module tb_a2d_spi_intf;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        strt  = 1'b0;
  logic [2:0]  ch    = 3'd0;
  logic        miso  = 1'b0;
  logic        sel   = 1'b0;

  a2d_spi_intf_if bus1();
  a2d_spi_intf_if bus2();

  assign bus1.strt_cnv = strt & ~sel;
  assign bus2.strt_cnv = strt & sel;
  assign bus1.chnnl    = ch;
  assign bus2.chnnl    = ch;
  assign bus1.MISO     = miso;
  assign bus2.MISO     = miso;

  a2d_spi_intf u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  a2d_spi_intf #(.GAP_CLKS(2)) u_dut_gap2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  logic        act_ss, act_sclk, act_mosi, act_cmplt;
  logic [11:0] act_res;
  assign act_ss    = sel ? bus2.SS_n      : bus1.SS_n;
  assign act_sclk  = sel ? bus2.SCLK      : bus1.SCLK;
  assign act_mosi  = sel ? bus2.MOSI      : bus1.MOSI;
  assign act_cmplt = sel ? bus2.cnv_cmplt : bus1.cnv_cmplt;
  assign act_res   = sel ? bus2.res       : bus1.res;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame monitor + A2D model (result word returned MSB first, one bit per SCLK fall)
  typedef struct {
    int          low;
    int          gap;
    int          ff;
    int          nr;
    int          nf;
    logic [15:0] mosi;
  } frm_t;

  frm_t        flog[$];
  time         t_fall, t_rise, t_first, t_acc, t_cmplt;
  int          gap_cur, nr, nf, bit_idx, n_cmplt;
  logic [15:0] mosi_sr, word;
  logic [11:0] f1, f2;
  logic        par;

  initial begin
    t_fall = 0; t_rise = 0; t_first = 0; t_acc = 0; t_cmplt = 0;
    gap_cur = 0; nr = 0; nf = 0; bit_idx = 0; n_cmplt = 0;
    mosi_sr = '0; word = '0; f1 = '0; f2 = '0; par = 1'b0;
  end

  always @(negedge act_ss) begin
    gap_cur = int'((($time - t_rise)) / 10);
    t_fall  = $time;
    t_first = 0;
    nr      = 0;
    nf      = 0;
    mosi_sr = '0;
    par     = ~par;
    word    = par ? {4'h0, f1} : {4'h0, f2};
    bit_idx = 16;
  end

  always @(posedge act_ss) begin
    frm_t r;
    r.low  = int'(($time - t_fall) / 10);
    r.gap  = gap_cur;
    r.ff   = (t_first == 0) ? -1 : int'((t_first - t_fall) / 10);
    r.nr   = nr;
    r.nf   = nf;
    r.mosi = mosi_sr;
    flog.push_back(r);
    t_rise = $time;
  end

  always @(posedge act_sclk) begin
    if (act_ss === 1'b0) begin
      nr++;
      mosi_sr = {mosi_sr[14:0], act_mosi};
    end
  end

  always @(negedge act_sclk) begin
    if (act_ss === 1'b0) begin
      if (nf == 0) t_first = $time;
      nf++;
      if (bit_idx > 0) begin
        bit_idx--;
        miso = word[bit_idx];
      end
    end
  end

  always @(posedge act_cmplt) begin
    t_cmplt = $time;
    n_cmplt++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_ss_n",  32'(bus1.SS_n), 32'h1);
    check_val("rst_sclk",  32'(bus1.SCLK), 32'h1);
    check_val("rst_mosi",  32'(bus1.MOSI), 32'h0);
    check_val("rst_cmplt", 32'(bus1.cnv_cmplt), 32'h0);
    check_val("rst_res",   32'(bus1.res), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    flog.delete();
    par     = 1'b0;
    n_cmplt = 0;
  endtask

  task automatic start_cnv(input logic [2:0] c, input logic [11:0] d1, input logic [11:0] d2);
    @(negedge clk);
    f1 = d1;
    f2 = d2;
    ch = c;
    strt = 1'b1;
    flog.delete();
    n_cmplt = 0;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    strt = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (act_cmplt === 1'b1) break;
      @(negedge clk);
    end
    check_val("done", 32'(act_cmplt), 32'h1);
  endtask

  task automatic check_conv(input int lat, input logic [11:0] r, input logic [15:0] cmd, input int gap);
    check_val("latency", 32'((t_cmplt - t_acc) / 10), 32'(lat));
    check_val("res", 32'(act_res), 32'(r));
    check_val("n_cmplt", 32'(n_cmplt), 32'h1);
    check_val("n_frames", 32'(flog.size()), 32'h2);
    if (flog.size() == 2) begin
      for (int k = 0; k < 2; k++) begin
        check_val("ss_low",     32'(flog[k].low), 32'd520);
        check_val("first_fall", 32'(flog[k].ff),  32'd9);
        check_val("sclk_rises", 32'(flog[k].nr),  32'd16);
        check_val("sclk_falls", 32'(flog[k].nf),  32'd16);
        check_val("mosi_cmd",   32'(flog[k].mosi), 32'(cmd));
      end
      check_val("gap_clks", 32'(flog[1].gap), 32'(gap));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset while idle
    do_reset();

    // Channel 5, A2D returns A5C in frame 2
    start_cnv(3'd5, 12'h3C3, 12'hA5C);
    wait_done(1200);
    check_conv(1072, 12'hA5C, 16'h2800, 32);
    repeat (50) @(negedge clk);
    check_val("hold_cmplt", 32'(act_cmplt), 32'h1);
    check_val("hold_res",   32'(act_res),   32'hA5C);

    // Back-to-back: ch7 -> FFF, then ch0 -> 001 with a request on the completion edge
    start_cnv(3'd7, 12'h000, 12'hFFF);
    check_val("b2b_clr1", 32'(act_cmplt), 32'h0);
    repeat (1071) @(negedge clk);
    check_val("not_early", 32'(act_cmplt), 32'h0);
    ch = 3'd0;
    f1 = 12'hEEE;
    f2 = 12'h001;
    strt = 1'b1;
    @(negedge clk);
    check_val("coinc_cmplt", 32'(act_cmplt), 32'h1);
    check_val("coinc_ss",    32'(act_ss),    32'h1);
    check_conv(1072, 12'hFFF, 16'h3800, 32);
    flog.delete();
    n_cmplt = 0;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    strt = 1'b0;
    check_val("b2b_clr2", 32'(act_cmplt), 32'h0);
    check_val("b2b_ss",   32'(act_ss),    32'h0);
    wait_done(1200);
    check_conv(1072, 12'h001, 16'h0000, 32);

    // Requests during FRAME1 and GAP with a different channel are ignored
    start_cnv(3'd1, 12'h555, 12'h123);
    repeat (200) @(negedge clk);
    ch = 3'd2;
    strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    repeat (330) @(negedge clk);
    check_val("in_gap_ss", 32'(act_ss), 32'h1);
    strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    wait_done(1200);
    check_conv(1072, 12'h123, 16'h0800, 32);
    repeat (1200) @(negedge clk);
    check_val("one_cmplt",   32'(n_cmplt),     32'h1);
    check_val("no_new_frm",  32'(flog.size()), 32'h2);
    check_val("still_cmplt", 32'(act_cmplt),   32'h1);

    // Reset mid-FRAME1 (SCLK low, MOSI high at that moment), then a clean run
    start_cnv(3'd6, 12'h000, 12'h777);
    repeat (109) @(negedge clk);
    check_val("pre_rst_ss", 32'(act_ss), 32'h0);
    do_reset();
    start_cnv(3'd6, 12'h111, 12'h6B7);
    wait_done(1200);
    check_conv(1072, 12'h6B7, 16'h3000, 32);

    // GAP_CLKS=2 instance
    @(negedge clk);
    sel = 1'b1;
    start_cnv(3'd4, 12'h0AA, 12'h9E1);
    wait_done(1200);
    check_conv(1042, 12'h9E1, 16'h2000, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
